// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with adjust-mode pair blinking.
// Digits are decoded in parallel and the registered output picks the active slot.

module seg7_dec (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   // active-low {g,f,e,d,c,b,a}; non-BCD codes blank the digit
   always_comb begin
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] minutes_1,
   input  logic [3:0] minutes_0,
   input  logic [3:0] seconds_1,
   input  logic [3:0] seconds_0,
   input  logic       adj,
   input  logic       sel,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);

   logic [RW-1:0]     rcnt;
   logic [BW-1:0]     bcnt;
   logic [1:0]        idx;
   logic              blink_phase;
   logic              blank;
   logic [3:0][3:0]   digits;
   logic [3:0][6:0]   dec_seg;

   assign digits = {minutes_1, minutes_0, seconds_1, seconds_0};

   for (genvar i = 0; i < 4; i++) begin : g_dec
      seg7_dec u_dec (.bcd(digits[i]), .seg(dec_seg[i]));
   end

   // idx[1] set means a minutes slot; sel=1 picks the seconds pair instead
   assign blank = adj & blink_phase & (sel ? ~idx[1] : idx[1]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rcnt <= '0;
         idx  <= '0;
      end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
         rcnt <= '0;
         idx  <= idx + 2'd1;
      end else begin
         rcnt <= rcnt + RW'(1);
      end
   end

   // held at zero outside adjust so every entry starts with a visible half-period
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcnt        <= '0;
         blink_phase <= 1'b0;
      end else if (!adj) begin
         bcnt        <= '0;
         blink_phase <= 1'b0;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
         bcnt        <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         bcnt <= bcnt + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else if (blank) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= dec_seg[idx];
         dp  <= (idx != 2'd2);
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver; expected outputs come from a cycle-count model
// of slot position and blink half-period, queued per edge and checked after it.

module tb_seg7_scan_driver;
   localparam int R = 4;
   localparam int B = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] minutes_1 = 4'd0, minutes_0 = 4'd0, seconds_1 = 4'd0, seconds_0 = 4'd0;
   logic       adj = 1'b0, sel = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       blank;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   t     = 0;   // edges since reset release
   int   n     = 0;   // consecutive edges with adj sampled high
   logic last_blank;
   int   last_idx;

   seg7_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
      .clk(clk), .rst(rst),
      .minutes_1(minutes_1), .minutes_0(minutes_0),
      .seconds_1(seconds_1), .seconds_0(seconds_0),
      .adj(adj), .sel(sel),
      .seg(seg), .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed={an,seg,dp}=%b expected=%b", tag, obs, expv);
      end
   endtask

   // one clock edge: push the model's prediction, advance, pop and compare
   task automatic cyc(input string tag);
      exp_t       e;
      int         tn, nn, ix;
      logic       ph, bl;
      logic [3:0] d;
      tn = t + 1;
      ix = ((tn - 1) / R) % 4;
      nn = adj ? n + 1 : 0;
      ph = adj ? ((((nn - 1) / B) % 2) == 1) : 1'b0;
      bl = adj && ph && (sel ? (ix < 2) : (ix >= 2));
      case (ix)
         0: d = seconds_0;
         1: d = seconds_1;
         2: d = minutes_0;
         default: d = minutes_1;
      endcase
      e.blank = bl;
      if (bl) begin
         e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
      end else begin
         e.an = ~(4'b0001 << ix); e.seg = dec(d); e.dp = (ix != 2);
      end
      sb.push_back(e);
      @(posedge clk); #1;
      t = tn; n = nn; last_idx = ix;
      e = sb.pop_front();
      last_blank = e.blank;
      chk(tag, {an, seg, dp}, {e.an, e.seg, e.dp});
   endtask

   initial begin
      bit found;
      // reset asserted between edges takes effect at once
      #3 rst = 1'b0;
      #1 chk("reset_async", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
      @(posedge clk); #1;
      minutes_1 = 4'd1; minutes_0 = 4'd2; seconds_1 = 4'd3; seconds_0 = 4'd4;
      rst = 1'b1; t = 0; n = 0;

      // normal scan; first slot after release is index 0
      cyc("scan_first_model");
      chk("scan_first", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
      for (int i = 0; i < 31; i++) cyc("scan");

      // blink minutes pair, then seconds pair without resetting the phase
      adj = 1'b1; sel = 1'b0;
      for (int i = 0; i < 64; i++) cyc("blink_min");
      sel = 1'b1;
      for (int i = 0; i < 64; i++) cyc("blink_sec");

      // invalid BCD blanks segments but still drives the anode
      adj = 1'b0; sel = 1'b0; seconds_0 = 4'hA;
      for (int i = 0; i < 16; i++) cyc("bad_bcd");
      seconds_0 = 4'd4;

      // mid-slot change of the leftmost digit
      for (int i = 0; i < 16 && !(((t / R) % 4) == 3 && (t % R) == 1); i++) cyc("seek_slot3");
      minutes_1 = 4'd5;
      cyc("midslot_model");
      chk("midslot", {an, seg, dp}, {4'b0111, 7'b0010010, 1'b1});
      for (int i = 0; i < 8; i++) cyc("midslot_after");

      // exit adjust while blanked, then re-enter
      adj = 1'b1; sel = 1'b0; found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         cyc("seek_blank");
         found = last_blank;
      end
      total++;
      assert (found) else begin
         bad++;
         $error("FAIL blank_seen observed=0 expected=1");
      end
      adj = 1'b0;
      cyc("exit_adj_model");
      chk("exit_adj_visible", {an[3] & an[2], seg == 7'b1111111}, {1'b0, 1'b0});
      for (int i = 0; i < 3; i++) cyc("exit_adj_after");
      adj = 1'b1;
      for (int i = 0; i < 40; i++) cyc("reenter");

      // reset mid-scan, then scanning restarts at index 0
      #2 rst = 1'b0;
      #1 chk("reset_midscan", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
      @(posedge clk); #1;
      adj = 1'b0; rst = 1'b1; t = 0; n = 0;
      cyc("post_reset_model");
      chk("post_reset_first", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
      for (int i = 0; i < 15; i++) cyc("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display back-end for the stopwatch; sits directly downstream of the minutes/seconds counter.
- Consumes the four BCD digits, adj and sel, and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- In adjust mode it blinks the selected digit pair.
- Owns its own refresh and blink timing, derived from the system clock.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.
- BLINK_DIV, 25000000: clk cycles per blink half-period (2 Hz blink at 100 MHz); must be >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- minutes_1  input  4  BCD tens of minutes (leftmost digit, an[3]).
- minutes_0  input  4  BCD units of minutes (an[2]).
- seconds_1  input  4  BCD tens of seconds (an[1]).
- seconds_0  input  4  BCD units of seconds (rightmost digit, an[0]).
- adj  input  1  1 = adjust mode; selected pair blinks.
- sel  input  1  0 = minutes pair selected; 1 = seconds pair selected.
- seg  output  7  active-low cathodes {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- an  output  4  active-low anodes, one-hot-low.

Behaviour:
- Reset (rst=0, async, takes effect immediately):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - refresh counter=0, digit index=0, blink counter=0, blink_phase=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - On the wrap cycle, the 2-bit digit index advances 0->1->2->3->0.
- Index-to-digit mapping:
  - 0 = seconds_0 / an=1110
  - 1 = seconds_1 / an=1101
  - 2 = minutes_0 / an=1011
  - 3 = minutes_1 / an=0111
- Output timing:
  - Outputs are registered, updated every clk from the current index, digit inputs, adj, sel and blink_phase.
  - Latency is 1 cycle; input changes appear on seg on the next edge.
  - Each digit therefore occupies exactly REFRESH_DIV consecutive cycles.
  - The first visible slot after reset release is index 0.
- Decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10-15 give seg=1111111 (blank); an still drives normally.
- Decimal point: dp=0 only while index=2 (separates minutes from seconds), else 1.
- Blink counter (adj=1):
  - Counts 0..BLINK_DIV-1.
  - blink_phase toggles on each wrap; first phase after entering adjust is visible (0).
- Blank condition: adj=1 and blink_phase=1 and the current index belongs to the selected pair.
  - sel=0 selects indices 2,3; sel=1 selects indices 0,1.
  - When blanked: an=1111, seg=1111111, dp=1.
  - Scanning continues through blanked slots; no slot is skipped.
- Blink counter (adj=0):
  - Blink counter and blink_phase are held at 0.
  - Re-entering adjust always starts with a visible half-period.
- sel change during adjust:
  - Takes effect on the next cycle.
  - blink_phase is not reset.
- Simultaneous events:
  - Refresh wrap and blink wrap on the same cycle are independent; both take effect.
  - adj falling while blanked makes the digit visible on the next cycle.
- Reset mid-scan: outputs go to reset values asynchronously; after release, scanning restarts at index 0.
- No combinational path from inputs to outputs.

Test Plan:
Benches use REFRESH_DIV=4, BLINK_DIV=16.
1. Reset: rst=0 at arbitrary time -> an=1111, seg=1111111, dp=1 without waiting for an edge. Release -> first slot an=1110.
2. Normal scan, adj=0, digits m1=1, m0=2, s1=3, s0=4 -> repeating 4-cycle slots:
   - an=1110 seg=0011001 dp=1
   - an=1101 seg=0110000 dp=1
   - an=1011 seg=0100100 dp=0
   - an=0111 seg=1111001 dp=1
3. Blink minutes, adj=1 sel=0:
   - Cycles 0-15 after adj rise: all four digits visible.
   - Cycles 16-31: slots for an[3]/an[2] show an=1111, seg=1111111, while an=1110/1101 still display '4','3'.
   - Pattern repeats.
   - Repeat with sel=1 -> seconds slots blank instead.
4. Invalid BCD: seconds_0=4'hA -> during slot 0, an=1110 and seg=1111111.
5. Mid-slot input change: minutes_1 changes 1->5 mid slot 3 -> seg becomes 0010010 on the next edge. Slot length is unchanged (4 cycles).
6. Exit adjust while blanked: adj 1->0 during blank phase -> next cycle selected digit visible. Re-asserting adj gives 16 visible cycles before the first blank.
